// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and the data-phase state machine states
// for the AHB-to-SRAM controller.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    OKAY  = 2'd0,
    ERROR = 2'd1
  } hresp_e;

  localparam logic [2:0] BYTE = 3'd0;
  localparam logic [2:0] HALF = 3'd1;
  localparam logic [2:0] WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_DLY,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// Little-endian byte-lane enables for a 32-bit beat, plus a flag for
// unsupported sizes and misaligned addresses.
module ahb_sram_be_gen
  import ahb_sram_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] hsize,
  output logic [3:0] be,
  output logic       err
);

  always_comb begin
    be  = 4'b0000;
    err = 1'b0;
    case (hsize)
      BYTE: be = 4'b0001 << addr_lo;
      HALF: begin
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
        err = addr_lo[0];
      end
      WORD: begin
        be  = 4'b1111;
        err = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave fronting a single-port synchronous SRAM: zero-wait reads,
// data-phase writes, one wait state on read-after-write, two-cycle ERROR.
module ahb_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic               hready,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [DATA_W-1:0]  hwdata,
  output logic               hready_resp,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  state_e             state_reg;
  logic [SRAM_AW-1:0] addr_reg;
  logic [3:0]         be_reg;
  logic               hready_resp_reg;
  hresp_e             hresp_reg;

  logic [3:0] be_addr;
  logic       align_err;
  logic       range_err;
  logic       xfer_err;
  logic       take;
  logic       unused_ok;

  ahb_sram_be_gen u_be_gen (
    .addr_lo (haddr[1:0]),
    .hsize   (hsize),
    .be      (be_addr),
    .err     (align_err)
  );

  assign range_err = |haddr[ADDR_W-1:SRAM_AW+2];
  assign xfer_err  = align_err | range_err;
  assign take      = hsel & hready & htrans[1] & hready_resp_reg;
  assign unused_ok = &{1'b0, hburst, htrans[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      be_reg          <= '0;
      hready_resp_reg <= 1'b1;
      hresp_reg       <= OKAY;
    end else begin
      case (state_reg)
        ST_RD_DLY: begin
          state_reg       <= ST_RD;
          hready_resp_reg <= 1'b1;
          hresp_reg       <= OKAY;
        end
        ST_ERR1: begin
          state_reg       <= ST_ERR2;
          hready_resp_reg <= 1'b1;
          hresp_reg       <= ERROR;
        end
        default: begin
          state_reg       <= ST_IDLE;
          hready_resp_reg <= 1'b1;
          hresp_reg       <= OKAY;
          if (take) begin
            addr_reg <= haddr[SRAM_AW+1:2];
            be_reg   <= be_addr;
            if (xfer_err) begin
              state_reg       <= ST_ERR1;
              hready_resp_reg <= 1'b0;
              hresp_reg       <= ERROR;
            end else if (hwrite) begin
              state_reg <= ST_WR;
            end else if (state_reg == ST_WR) begin
              // SRAM port is busy committing the write this cycle
              state_reg       <= ST_RD_DLY;
              hready_resp_reg <= 1'b0;
            end else begin
              state_reg <= ST_RD;
            end
          end
        end
      endcase
    end
  end

  // Reads launch straight from the address phase; gating with hresetn keeps
  // the port quiet the instant reset asserts.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (hresetn) begin
      case (state_reg)
        ST_WR: begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_be    = be_reg;
          sram_addr  = addr_reg;
          sram_wdata = hwdata;
        end
        ST_RD_DLY: begin
          sram_cs   = 1'b1;
          sram_be   = be_reg;
          sram_addr = addr_reg;
        end
        default: begin
          if (take && !xfer_err && !hwrite) begin
            sram_cs   = 1'b1;
            sram_be   = be_addr;
            sram_addr = haddr[SRAM_AW+1:2];
          end
        end
      endcase
    end
  end

  assign hrdata      = (hresetn && state_reg == ST_RD) ? sram_rdata : '0;
  assign hready_resp = hready_resp_reg;
  assign hresp       = hresp_reg;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl with a behavioural SRAM and a
// scoreboard of outstanding AHB data phases.
module tb_ahb_sram_ctrl;
  import ahb_sram_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        sram_cs;
  logic        sram_we;
  logic [3:0]  sram_be;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        hold_low;
  logic [31:0] sram_mem [16384];
  logic [31:0] ref_mem  [16384];

  typedef struct {
    logic        wr;
    logic        err;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;

  assign hready = hold_low ? 1'b0 : hready_resp;

  ahb_sram_ctrl dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel        (hsel),
    .hready      (hready),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hburst      (hburst),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .hready_resp (hready_resp),
    .hresp       (hresp),
    .hrdata      (hrdata),
    .sram_cs     (sram_cs),
    .sram_we     (sram_we),
    .sram_be     (sram_be),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  always @(posedge hclk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
    case (size)
      3'd0:    return 4'b0001 << addr[1:0];
      3'd1:    return addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // One AHB cycle-slot: present an address phase, finish the current data
  // phase (absorbing any stall cycles), and record the new transfer if taken.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic bad);
    exp_t e;
    exp_t n;
    int   waits;
    logic done, dp_wr, acc, exp_cs;
    logic [3:0] be;
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = (sb.size() > 0 && sb[0].wr) ? sb[0].data : 32'h0;
    waits  = 0;
    done   = 1'b0;
    dp_wr  = 1'b0;
    acc    = 1'b0;
    while (!done) begin
      @(negedge hclk);
      acc = sel & hready & trans[1];
      if (sb.size() == 0) begin
        exp_cs = acc & !bad & !wr;
        checks++;
        if (hready_resp !== 1'b1 || hresp !== 2'd0) begin
          errors++;
          $display("FAIL idle_resp: ready=%b resp=%0d, required ready=1 resp=0", hready_resp, hresp);
        end
        done = 1'b1;
      end else if (hready_resp === 1'b0) begin
        waits++;
        exp_cs = !sb[0].err & !sb[0].wr;
        checks++;
        if (waits > sb[0].waits || hresp !== {1'b0, sb[0].err}) begin
          errors++;
          $display("FAIL stall @%h: wait %0d resp=%0d, required <=%0d waits resp=%0d",
                   sb[0].addr, waits, hresp, sb[0].waits, sb[0].err);
        end
        if (waits >= 4) begin
          errors++;
          $display("FAIL stall_timeout @%h: still stalled after %0d cycles, required %0d",
                   sb[0].addr, waits, sb[0].waits);
          void'(sb.pop_front());
          done = 1'b1;
        end
      end else begin
        e = sb.pop_front();
        $display("txn %s addr=%h size=%0d data=%h waits=%0d resp=%0d",
                 e.wr ? "WR" : "RD", e.addr, e.size, e.wr ? e.data : hrdata, waits, hresp);
        checks++;
        if (hresp !== {1'b0, e.err} || waits != e.waits) begin
          errors++;
          $display("FAIL resp @%h: resp=%0d waits=%0d, required resp=%0d waits=%0d",
                   e.addr, hresp, waits, e.err, e.waits);
        end
        if (!e.wr && !e.err) begin
          checks++;
          if (hrdata !== e.data) begin
            errors++;
            $display("FAIL rdata @%h: got %h, required %h", e.addr, hrdata, e.data);
          end
        end
        if (e.wr && !e.err) begin
          be = exp_be(e.size, e.addr);
          checks++;
          if (sram_we !== 1'b1 || sram_be !== be || sram_addr !== e.addr[15:2] || sram_wdata !== e.data) begin
            errors++;
            $display("FAIL sram_write @%h: we=%b be=%b addr=%h wdata=%h, required we=1 be=%b addr=%h wdata=%h",
                     e.addr, sram_we, sram_be, sram_addr, sram_wdata, be, e.addr[15:2], e.data);
          end
          for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[e.addr[15:2]][8*i +: 8] = e.data[8*i +: 8];
        end
        dp_wr  = e.wr & !e.err;
        exp_cs = dp_wr | (acc & !bad & !wr);
        done   = 1'b1;
      end
      checks++;
      if (sram_cs !== exp_cs) begin
        errors++;
        $display("FAIL sram_cs @%h: got %b, required %b", addr, sram_cs, exp_cs);
      end
    end
    @(posedge hclk);
    if (acc) begin
      n.wr    = wr;
      n.err   = bad;
      n.size  = size;
      n.addr  = addr;
      n.data  = wr ? wdata : (bad ? 32'h0 : ref_mem[addr[15:2]]);
      n.waits = bad ? 1 : ((!wr && dp_wr) ? 1 : 0);
      sb.push_back(n);
    end
    #1;
  endtask

  task automatic idle_beat();
    beat(1'b0, IDLE, 1'b0, WORD, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    #23;
    checks++;
    if (hready_resp !== 1'b1 || hresp !== 2'd0 || hrdata !== 32'h0 || sram_cs !== 1'b0 ||
        sram_we !== 1'b0 || sram_be !== 4'b0 || sram_addr !== 14'h0 || sram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b resp=%0d rdata=%h cs=%b we=%b be=%b addr=%h wdata=%h, required 1/0/0/0/0/0/0/0",
               hready_resp, hresp, hrdata, sram_cs, sram_we, sram_be, sram_addr, sram_wdata);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_word_rw();
    beat(1'b1, NONSEQ, 1'b1, WORD, 32'h10, 32'hDEADBEEF, 1'b0);
    beat(1'b1, IDLE,   1'b0, WORD, 32'h0,  32'h0,        1'b0);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h10, 32'h0,        1'b0);
    idle_beat();
  endtask

  task automatic test_back_to_back();
    beat(1'b1, NONSEQ, 1'b1, WORD, 32'h20, 32'h12345678, 1'b0);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h20, 32'h0,        1'b0);
    idle_beat();
  endtask

  task automatic test_byte_half();
    beat(1'b1, NONSEQ, 1'b1, WORD, 32'h30, 32'h00000000, 1'b0);
    beat(1'b1, SEQ,    1'b1, WORD, 32'h34, 32'h00000000, 1'b0);
    beat(1'b1, NONSEQ, 1'b1, BYTE, 32'h31, 32'h0000AA00, 1'b0);
    beat(1'b1, NONSEQ, 1'b1, BYTE, 32'h33, 32'hBB000000, 1'b0);
    beat(1'b1, NONSEQ, 1'b1, HALF, 32'h34, 32'h0000CCDD, 1'b0);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h30, 32'h0,        1'b0);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h34, 32'h0,        1'b0);
    idle_beat();
    checks++;
    if (ref_mem[12] !== 32'hBB00AA00 || ref_mem[13] !== 32'h0000CCDD) begin
      errors++;
      $display("FAIL lane_merge: words %h %h, required BB00AA00 0000CCDD", ref_mem[12], ref_mem[13]);
    end
  endtask

  task automatic test_errors();
    beat(1'b1, NONSEQ, 1'b0, HALF, 32'h41,    32'h0,      1'b1);
    beat(1'b1, NONSEQ, 1'b1, WORD, 32'h42,    32'h5555AAAA, 1'b1);
    beat(1'b1, NONSEQ, 1'b0, 3'd3, 32'h40,    32'h0,      1'b1);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h10000, 32'h0,      1'b1);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h10,    32'h0,      1'b0);
    idle_beat();
  endtask

  task automatic test_noops();
    beat(1'b1, BUSY,   1'b0, WORD, 32'h10, 32'h0, 1'b0);
    beat(1'b0, NONSEQ, 1'b1, WORD, 32'h10, 32'h0, 1'b0);
    hold_low = 1'b1;
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h10, 32'h0, 1'b0);
    hold_low = 1'b0;
    idle_beat();
  endtask

  task automatic test_mid_reset();
    beat(1'b1, NONSEQ, 1'b1, WORD, 32'h20, 32'hCAFEF00D, 1'b0);
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h20, 32'h0,        1'b0);
    checks++;
    if (sram_cs !== 1'b1 || hready_resp !== 1'b0) begin
      errors++;
      $display("FAIL rd_dly_entry: cs=%b ready=%b, required cs=1 ready=0", sram_cs, hready_resp);
    end
    #2;
    hresetn = 1'b0;
    #1;
    checks++;
    if (sram_cs !== 1'b0 || hready_resp !== 1'b1 || hrdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: cs=%b ready=%b rdata=%h, required cs=0 ready=1 rdata=0",
               sram_cs, hready_resp, hrdata);
    end
    sb.delete();
    hsel   = 1'b0;
    htrans = IDLE;
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    beat(1'b1, NONSEQ, 1'b0, WORD, 32'h10, 32'h0, 1'b0);
    idle_beat();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    hold_low   = 1'b0;
    hsel       = 1'b0;
    htrans     = IDLE;
    hwrite     = 1'b0;
    hsize      = WORD;
    hburst     = 3'd0;
    haddr      = 32'h0;
    hwdata     = 32'h0;
    sram_rdata = 32'h0;
    test_reset();
    test_word_rw();
    test_back_to_back();
    test_byte_half();
    test_errors();
    test_noops();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
